// File: rtl/pulse_emitter.sv
// Pulse emitter: plays queued pulse lengths (in baud ticks) out on pulse_out,
// back-to-back with a fixed low gap. Lengths arrive on a valid/ready handshake
// into a small FIFO; zero-length requests are dropped, oversize ones saturate.
module pulse_emitter #(
    parameter int unsigned CLK_F      = 25000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DIV        = CLK_F / BAUD_RATE,
    parameter int unsigned MAX_TICKS  = 9600,
    parameter int unsigned GAP_TICKS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [14:0]                         len_in,
    input  logic                                len_valid,
    output logic                                len_ready,
    output logic                                pulse_out,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int unsigned TW  = $clog2(MAX_TICKS + 1);
    localparam int unsigned PSW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e          state_q, state_d;
    logic [PSW-1:0]  presc_q, presc_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TW-1:0]   len_q, len_d;
    logic            pulse_q, pulse_d;
    logic            done_q, done_d;

    logic [TW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic            push, pop, tick;
    logic [TW-1:0]   len_sat;

    assign len_ready  = (count_q != CW'(FIFO_DEPTH));
    assign fifo_count = count_q;
    assign pulse_out  = pulse_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);

    // Zero-length requests complete the handshake but never reach the FIFO.
    assign push    = len_valid && len_ready && (len_in != 15'd0);
    assign len_sat = (32'(len_in) > MAX_TICKS) ? TW'(MAX_TICKS) : TW'(len_in);
    assign tick    = (presc_q == PSW'(DIV));

    // FIFO storage; emptiness is governed by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= len_sat;
        end
    end

    // FIFO occupancy bookkeeping for simultaneous push/pop.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // FSM next state: pop and raise in IDLE, count ticks in PULSE and GAP.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;
        len_d      = len_q;
        pulse_d    = pulse_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    len_d      = mem_q[rd_ptr_q];
                    presc_d    = '0;
                    tick_cnt_d = '0;
                    pulse_d    = 1'b1;
                    state_d    = StPulse;
                end
            end
            StPulse: begin
                presc_d = tick ? '0 : presc_q + PSW'(1);
                if (tick) begin
                    if (tick_cnt_q == len_q - TW'(1)) begin
                        pulse_d    = 1'b0;
                        done_d     = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = StGap;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            StGap: begin
                presc_d = tick ? '0 : presc_q + PSW'(1);
                if (tick) begin
                    if (tick_cnt_q == TW'(GAP_TICKS - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: begin
                pulse_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // FSM and datapath registers; reset drops pulse_out immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            len_q      <= '0;
            pulse_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            len_q      <= len_d;
            pulse_q    <= pulse_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_emitter.sv
// Self-checking bench for pulse_emitter with DIV=3 (4 clocks per tick).
module tb_pulse_emitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] len_in = '0;
    logic        len_valid = 1'b0;
    logic        len_ready, pulse_out, busy, done;
    logic [2:0]  fifo_count;

    pulse_emitter #(
        .DIV        (3),
        .MAX_TICKS  (9600),
        .GAP_TICKS  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .len_in     (len_in),
        .len_valid  (len_valid),
        .len_ready  (len_ready),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: widths of high runs, low runs ending in a rise, done strobes.
    int hi_q[$];
    int lo_q[$];
    int done_cnt = 0;
    int stray_done = 0;
    int hi_run = 0, lo_run = 0;
    logic prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev = 1'b0;
            hi_run = 0;
            lo_run = 0;
        end else begin
            if (pulse_out) begin
                if (!prev) begin
                    lo_q.push_back(lo_run);
                    lo_run = 0;
                end
                hi_run++;
            end else begin
                if (prev) begin
                    hi_q.push_back(hi_run);
                    hi_run = 0;
                end
                lo_run++;
            end
            if (done) begin
                done_cnt++;
                if (!(prev && !pulse_out)) stray_done++;
            end
            prev = pulse_out;
        end
    end

    // Present one length for one edge once len_ready allows it.
    task automatic push(input logic [14:0] len);
        int guard = 0;
        while (!len_ready && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50000) check("push_timeout", 1, 0);
        len_in = len;
        len_valid = 1'b1;
        @(negedge clk);
        len_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input string name);
        int guard = 0;
        while (hi_q.size() < n && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50000) check(name, hi_q.size(), n);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || fifo_count != 0) && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50000) check("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [14:0] len;
        int          exp_hi;   // -1: no pulse expected
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, n_exp, k, guard;

        vecs[0] = '{15'd3,     12};
        vecs[1] = '{15'd1,     4};
        vecs[2] = '{15'd7,     28};
        vecs[3] = '{15'd0,     -1};
        vecs[4] = '{15'd20000, 38400};
        vecs[5] = '{15'd2,     8};
        vecs[6] = '{15'd9,     36};
        vecs[7] = '{15'd100,   400};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pulse_out", int'(pulse_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_len_ready", int'(len_ready), 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single pulse of 5 ticks: latency, width, done, busy tail
        push(15'd5);
        check("lat_edge1_pulse", int'(pulse_out), 0);
        check("lat_edge1_count", int'(fifo_count), 1);
        @(negedge clk);
        check("lat_edge2_pulse", int'(pulse_out), 1);
        check("lat_edge2_busy", int'(busy), 1);
        check("lat_edge2_count", int'(fifo_count), 0);
        guard = 0;
        while (pulse_out && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("p5_fall_seen", int'(pulse_out), 0);
        check("p5_done_at_fall", int'(done), 1);
        @(negedge clk);
        check("p5_done_one_clk", int'(done), 0);
        repeat (2) @(negedge clk);
        check("p5_busy_in_gap", int'(busy), 1);
        @(negedge clk);
        check("p5_busy_after_gap", int'(busy), 0);
        check("p5_high_width", (hi_q.size() > 0) ? hi_q[0] : -1, 20);
        check("p5_done_count", done_cnt, 1);

        // Table: back-to-back, zero drop, saturation, loopback-style lengths
        wait_idle();
        hi_q.delete();
        lo_q.delete();
        d0 = done_cnt;
        n_exp = 0;
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].len);
            if (vecs[i].exp_hi >= 0) n_exp++;
        end
        wait_pulses(n_exp, "tbl_pulse_timeout");
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_hi >= 0) begin
                check($sformatf("tbl_hi_len%0d", vecs[i].len),
                      (k < hi_q.size()) ? hi_q[k] : -1, vecs[i].exp_hi);
                if (k > 0)
                    check($sformatf("tbl_gap_before_len%0d", vecs[i].len),
                          (k < lo_q.size()) ? lo_q[k] : -1, 5);
                k++;
            end
        end
        repeat (20) @(negedge clk);
        check("tbl_done_count", done_cnt - d0, n_exp);
        check("tbl_no_extra_pulse", hi_q.size(), n_exp);

        // Overflow: hold len_valid for 6 cycles while a 10-tick pulse runs
        wait_idle();
        hi_q.delete();
        d0 = done_cnt;
        push(15'd10);
        @(negedge clk);
        check("ovf_first_running", int'(pulse_out), 1);
        for (int i = 0; i < 6; i++) begin
            len_in = 15'(2 + i);
            len_valid = 1'b1;
            @(negedge clk);
        end
        len_valid = 1'b0;
        check("ovf_fifo_full", int'(fifo_count), 4);
        check("ovf_not_ready", int'(len_ready), 0);
        wait_pulses(5, "ovf_pulse_timeout");
        repeat (200) @(negedge clk);
        check("ovf_pulse_count", hi_q.size(), 5);
        for (int i = 0; i < 5 && i < hi_q.size(); i++)
            check($sformatf("ovf_hi_%0d", i), hi_q[i], (i == 0) ? 40 : 4 * (i + 1));
        check("ovf_done_count", done_cnt - d0, 5);

        // Reset 6 clocks into a 10-tick pulse with another length queued
        wait_idle();
        hi_q.delete();
        push(15'd10);
        push(15'd3);
        guard = 0;
        while (!pulse_out && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_pulse_out", int'(pulse_out), 0);
        check("rst_mid_fifo_count", int'(fifo_count), 0);
        check("rst_mid_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_stays_low", int'(pulse_out), 0);
        hi_q.delete();
        push(15'd4);
        wait_pulses(1, "post_rst_timeout");
        check("post_rst_hi", (hi_q.size() > 0) ? hi_q[0] : -1, 16);
        check("stray_done", stray_done, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
